// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle main control FSM and the MIPS datapath.
// The controller takes the master side; the datapath (or a bench) takes the slave side.
interface multicycle_ctrl_if #(
  parameter int STATE_WIDTH = 4
);
  logic [5:0]             opcode;
  logic                   memReady;
  logic                   ctrlPCWrite;
  logic                   ctrlPCWriteCond;
  logic                   ctrlIorD;
  logic                   ctrlMemRead;
  logic                   ctrlMemWrite;
  logic                   ctrlIRWrite;
  logic                   ctrlMemToReg;
  logic                   ctrlRegDst;
  logic                   ctrlRegWrite;
  logic                   ctrlALUSrcA;
  logic [1:0]             ctrlALUSrcB;
  logic [1:0]             ctrlALUOp;
  logic [1:0]             ctrlPCSource;
  logic                   illegalOp;
  logic                   memFault;
  logic [STATE_WIDTH-1:0] state;

  modport master (
    input  opcode, memReady,
    output ctrlPCWrite, ctrlPCWriteCond, ctrlIorD, ctrlMemRead, ctrlMemWrite,
           ctrlIRWrite, ctrlMemToReg, ctrlRegDst, ctrlRegWrite, ctrlALUSrcA,
           ctrlALUSrcB, ctrlALUOp, ctrlPCSource, illegalOp, memFault, state
  );

  modport slave (
    output opcode, memReady,
    input  ctrlPCWrite, ctrlPCWriteCond, ctrlIorD, ctrlMemRead, ctrlMemWrite,
           ctrlIRWrite, ctrlMemToReg, ctrlRegDst, ctrlRegWrite, ctrlALUSrcA,
           ctrlALUSrcB, ctrlALUOp, ctrlPCSource, illegalOp, memFault, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control: Moore FSM sequencing fetch, decode, execute,
// memory and write-back, with a bounded memory-wait counter and sticky traps
// for illegal opcodes and memory timeouts. Control strobes are registered
// alongside the state; only IRWrite/PCWrite in FETCH combine with memReady.
module multicycle_ctrl #(
  parameter int WAIT_LIMIT    = 15,
  parameter int USE_MEM_READY = 1,
  parameter int STATE_WIDTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam int              CNT_W     = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);

  // Registered Moore strobes; 'fetch' marks the state whose IRWrite/PCWrite
  // follow memReady combinationally.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       fetch;
  } ctrl_t;

  // Per-state control word; anything not set stays 0 (TRAP drives nothing).
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.fetch     = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      default: ;
    endcase
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       op_q, op_d;
  logic             illegal_q, illegal_d;
  logic             fault_q, fault_d;
  ctrl_t            ctrl_q;

  logic mem_rdy;
  logic wait_st;
  logic timeout;

  assign mem_rdy = (USE_MEM_READY != 0) ? bus.memReady : 1'b1;
  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout = wait_st && !mem_rdy && (cnt_q == CNT_LIMIT);

  // Next state, opcode latch, wait counter and trap causes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    fault_d   = fault_q;

    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        op_d = bus.opcode;
        case (bus.opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      // Only lw/sw reach MEMADR, so the latched opcode picks read vs write.
      S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase

    // A memory state that has already waited WAIT_LIMIT cycles and still sees
    // no ready gives up; a ready on that same cycle completes normally.
    if (timeout) begin
      state_d = S_TRAP;
      fault_d = 1'b1;
    end

    // Counter restarts whenever a state is entered and counts stalled cycles.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (wait_st && !mem_rdy && (cnt_q != CNT_LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, counter, latch, flags and registered strobes; reset aborts instantly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      ctrl_q    <= ctrl_for(S_FETCH);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
      ctrl_q    <= ctrl_for(state_d);
    end
  end

  assign bus.ctrlPCWrite     = ctrl_q.pc_write | (ctrl_q.fetch & mem_rdy);
  assign bus.ctrlIRWrite     = ctrl_q.fetch & mem_rdy;
  assign bus.ctrlPCWriteCond = ctrl_q.pc_write_cond;
  assign bus.ctrlIorD        = ctrl_q.iord;
  assign bus.ctrlMemRead     = ctrl_q.mem_read;
  assign bus.ctrlMemWrite    = ctrl_q.mem_write;
  assign bus.ctrlMemToReg    = ctrl_q.mem_to_reg;
  assign bus.ctrlRegDst      = ctrl_q.reg_dst;
  assign bus.ctrlRegWrite    = ctrl_q.reg_write;
  assign bus.ctrlALUSrcA     = ctrl_q.alu_src_a;
  assign bus.ctrlALUSrcB     = ctrl_q.alu_src_b;
  assign bus.ctrlALUOp       = ctrl_q.alu_op;
  assign bus.ctrlPCSource    = ctrl_q.pc_source;
  assign bus.illegalOp       = illegal_q;
  assign bus.memFault        = fault_q;
  assign bus.state           = STATE_WIDTH'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction sequences push the expected
// state/flags per cycle into a scoreboard; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ILL  = 6'b111111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.STATE_WIDTH(4)) bus ();

  multicycle_ctrl #(
    .WAIT_LIMIT(15),
    .USE_MEM_READY(1),
    .STATE_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         tag;
    logic [3:0] st;
    logic       rdy;
    logic       ill;
    logic       flt;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   tag     = 0;
  logic exp_ill = 1'b0;
  logic exp_flt = 1'b0;

  // {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
  //  RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0]}
  wire [15:0] act_ctrl = {bus.ctrlPCWrite, bus.ctrlPCWriteCond, bus.ctrlIorD,
                          bus.ctrlMemRead, bus.ctrlMemWrite, bus.ctrlIRWrite,
                          bus.ctrlMemToReg, bus.ctrlRegDst, bus.ctrlRegWrite,
                          bus.ctrlALUSrcA, bus.ctrlALUSrcB, bus.ctrlALUOp,
                          bus.ctrlPCSource};

  // Expected strobes taken from the per-state output table.
  function automatic logic [15:0] spec_ctrl(input logic [3:0] st, input logic rdy);
    logic [15:0] v;
    case (st)
      4'd0:  v = {rdy, 1'b0, 1'b0, 1'b1, 1'b0, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
      4'd1:  v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00};
      4'd2,
      4'd10: v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00};
      4'd3:  v = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
      4'd4:  v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
      4'd5:  v = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
      4'd6:  v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00};
      4'd7:  v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
      4'd8:  v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01};
      4'd9:  v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10};
      4'd11: v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input int tg, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s (t%0d): got %0h, expected %0h", nm, tg, act, expv);
    end
  endtask

  // Monitor: one expectation per cycle, compared away from the rising edge.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("state", e.tag, 32'(bus.state), 32'(e.st));
      chk("ctrl", e.tag, 32'(act_ctrl), 32'(spec_ctrl(e.st, e.rdy)));
      chk("flags", e.tag, 32'({bus.illegalOp, bus.memFault}), 32'({e.ill, e.flt}));
    end
  end

  // Drive one cycle's inputs and queue what the controller should show.
  task automatic cyc(input logic [5:0] op, input logic rdy, input logic [3:0] st);
    exp_t e;
    bus.opcode   = op;
    bus.memReady = rdy;
    e.tag = tag; e.st = st; e.rdy = rdy; e.ill = exp_ill; e.flt = exp_flt;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    exp_ill = 1'b0;
    exp_flt = 1'b0;
    cyc(OP_R, 1'b1, 4'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.opcode   = OP_R;
    bus.memReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tag = 0; do_reset();

    tag = 1; // lw, no waits
    cyc(OP_LW, 1'b1, 4'd0); cyc(OP_LW, 1'b1, 4'd1); cyc(OP_LW, 1'b1, 4'd2);
    cyc(OP_LW, 1'b1, 4'd3); cyc(OP_LW, 1'b1, 4'd4);

    tag = 2; // R-type with 3-cycle fetch stall; memReady ignored in EXEC
    repeat (3) cyc(OP_R, 1'b0, 4'd0);
    cyc(OP_R, 1'b1, 4'd0); cyc(OP_R, 1'b0, 4'd1); cyc(OP_R, 1'b0, 4'd6); cyc(OP_R, 1'b1, 4'd7);

    tag = 3; // beq
    cyc(OP_BEQ, 1'b1, 4'd0); cyc(OP_BEQ, 1'b1, 4'd1); cyc(OP_BEQ, 1'b1, 4'd8);
    tag = 4; // j
    cyc(OP_J, 1'b1, 4'd0); cyc(OP_J, 1'b1, 4'd1); cyc(OP_J, 1'b1, 4'd9);
    tag = 5; // addi
    cyc(OP_ADDI, 1'b1, 4'd0); cyc(OP_ADDI, 1'b1, 4'd1);
    cyc(OP_ADDI, 1'b1, 4'd10); cyc(OP_ADDI, 1'b1, 4'd11);

    tag = 6; // sw; live opcode switched to lw after DECODE must not matter
    cyc(OP_SW, 1'b1, 4'd0); cyc(OP_SW, 1'b1, 4'd1); cyc(OP_LW, 1'b1, 4'd2);
    cyc(OP_LW, 1'b0, 4'd5); cyc(OP_LW, 1'b1, 4'd5);

    tag = 7; // lw: ready arrives exactly on the limit cycle
    cyc(OP_LW, 1'b1, 4'd0); cyc(OP_LW, 1'b1, 4'd1); cyc(OP_LW, 1'b1, 4'd2);
    repeat (15) cyc(OP_LW, 1'b0, 4'd3);
    cyc(OP_LW, 1'b1, 4'd3); cyc(OP_LW, 1'b1, 4'd4);

    tag = 8; // illegal opcode traps and holds
    cyc(OP_ILL, 1'b1, 4'd0); cyc(OP_ILL, 1'b1, 4'd1);
    exp_ill = 1'b1;
    for (int i = 0; i < 11; i++) cyc(OP_LW, 1'(i), 4'd15);
    tag = 9; do_reset();

    tag = 10; // sw stuck in MEMWR: 16 cycles then memory-fault trap
    cyc(OP_SW, 1'b1, 4'd0); cyc(OP_SW, 1'b1, 4'd1); cyc(OP_SW, 1'b1, 4'd2);
    repeat (16) cyc(OP_SW, 1'b0, 4'd5);
    exp_flt = 1'b1;
    cyc(OP_SW, 1'b0, 4'd15); cyc(OP_SW, 1'b1, 4'd15); cyc(OP_SW, 1'b0, 4'd15);
    tag = 11; do_reset();

    tag = 12; // reset raised in MEMRD aborts before the next edge
    cyc(OP_LW, 1'b1, 4'd0); cyc(OP_LW, 1'b1, 4'd1); cyc(OP_LW, 1'b1, 4'd2);
    cyc(OP_LW, 1'b0, 4'd3);
    bus.memReady = 1'b0;
    begin
      exp_t e;
      e.tag = tag; e.st = 4'd3; e.rdy = 1'b0; e.ill = 1'b0; e.flt = 1'b0;
      sbq.push_back(e);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", tag, 32'(bus.state), 32'd0);
    chk("async_rst_regwrite", tag, 32'(bus.ctrlRegWrite), 32'd0);
    chk("async_rst_memread", tag, 32'(bus.ctrlMemRead), 32'd1);
    @(posedge clk);
    #1;
    tag = 13; do_reset();
    cyc(OP_LW, 1'b1, 4'd0); cyc(OP_LW, 1'b1, 4'd1); cyc(OP_LW, 1'b1, 4'd2);
    cyc(OP_LW, 1'b1, 4'd3); cyc(OP_LW, 1'b1, 4'd4); cyc(OP_LW, 1'b1, 4'd0);

    begin
      int budget;
      budget = 0;
      while (sbq.size() > 0 && budget < 10) begin
        @(posedge clk);
        budget++;
      end
      chk("scoreboard_drained", tag, 32'(sbq.size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle main control unit for the MIPS core: a Moore FSM that sequences fetch, decode, execute, memory and write-back over several clocks. It replaces single-cycle combinational decode with registered state, adds a memory ready/wait handshake with a bounded wait counter, and traps on illegal opcodes. It sits between the instruction register's opcode field and the datapath muxes, register file, ALU control and memory port.

## Interface
- WAIT_LIMIT, 15: maximum number of consecutive cycles a memory state waits for `memReady`. On the next cycle it traps.
- USE_MEM_READY, 1: 1 honours `memReady`; 0 treats `memReady` as constant 1, so there are no waits and no timeouts.
- STATE_WIDTH, 4: width of the `state` debug output (≥4).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction-register bits [31:26]; sampled in DECODE.
- memReady  in  1  memory has completed the current read or write this cycle.
- ctrlPCWrite  out  1  unconditional PC load.
- ctrlPCWriteCond  out  1  PC load qualified by ALU zero (beq).
- ctrlIorD  out  1  memory address source: 0 = PC, 1 = ALUOut.
- ctrlMemRead, ctrlMemWrite  out  1 each  memory strobes.
- ctrlIRWrite  out  1  instruction-register load.
- ctrlMemToReg  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- ctrlRegDst  out  1  destination register: 0 = rt, 1 = rd.
- ctrlRegWrite  out  1  register-file write enable.
- ctrlALUSrcA  out  1  ALU A input: 0 = PC, 1 = rs.
- ctrlALUSrcB  out  2  ALU B input: 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = immediate << 2.
- ctrlALUOp  out  2  to the ALU control: 00 = add, 01 = sub, 10 = take funct field.
- ctrlPCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegalOp, memFault  out  1 each  sticky trap causes.
- state  out  STATE_WIDTH  current state encoding, for debug.

## Operation
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=15.
- Opcode decode in DECODE:
  - 000000 → EXEC
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDIEX
  - any other opcode → TRAP, with illegalOp = 1.
- Per-state outputs (any output not listed is 0):
  - FETCH: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite equal `memReady` (the only Mealy terms).
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: MemRead, IorD=1.
  - MEMWR: MemWrite, IorD=1.
  - MEMWB: RegWrite, MemToReg=1, RegDst=0.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - RWB: RegWrite, RegDst=1, MemToReg=0.
  - ADDIWB: RegWrite, RegDst=0, MemToReg=0.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01.
  - JUMP: PCWrite, PCSource=10.
  - TRAP: all strobes 0; the state is held until reset.
- Transitions:
  - FETCH→DECODE when `memReady`, otherwise stay in FETCH.
  - MEMADR→MEMRD (lw) or MEMWR (sw), selected by the opcode latched in DECODE.
  - MEMRD→MEMWB when `memReady`.
  - MEMWR→FETCH when `memReady`.
  - EXEC→RWB, ADDIEX→ADDIWB.
  - MEMWB, RWB, ADDIWB, BRANCH and JUMP → FETCH.
- Opcode latch: the opcode is captured into an internal register on the DECODE cycle. Later states use the latched copy, not the live input.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD and MEMWR.
  - Increments on each cycle spent in one of those states with `memReady` = 0; saturates at WAIT_LIMIT.
  - If the counter equals WAIT_LIMIT and `memReady` = 0, the next state is TRAP with memFault = 1.
  - `memReady` = 1 on the limit cycle itself completes normally.
- Trap flags: illegalOp and memFault are cleared only by `rst`.

## Timing
- Reset: `rst` high asynchronously forces state = FETCH, wait counter = 0, opcode latch = 0, illegalOp = memFault = 0. All outputs then take their FETCH values; IRWrite and PCWrite follow `memReady`.
- A reset asserted mid-instruction aborts it immediately. No partial write-back occurs after `rst` rises.
- Cycle counts with zero wait: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4. Each memory state adds one cycle per cycle of `memReady` = 0.
- `memReady` is sampled only in FETCH, MEMRD and MEMWR, and ignored in every other state.
- The state register updates on the rising edge of `clk`. Outputs are stable one combinational delay after the edge, except IRWrite and PCWrite in FETCH.

## Test plan
- Reset: `rst` pulse with `memReady` = 1 → state = 0, MemRead = 1, IRWrite = 1, PCWrite = 1, illegalOp = memFault = 0.
- lw: opcode 100011, `memReady` = 1 throughout → states 0,1,2,3,4,0 on consecutive clocks; RegWrite and MemToReg are 1 only in state 4.
- Fetch wait: `memReady` low for 3 cycles in FETCH → state stays 0 for 4 cycles; IRWrite is 1 only on the 4th cycle; then DECODE.
- beq then j: opcode 000100 → states 0,1,8,0 with PCWriteCond = 1 in state 8. Opcode 000010 → states 0,1,9,0 with PCWrite = 1 and PCSource = 10.
- Faults: opcode 111111 → states 0,1,15 with illegalOp = 1, held for 10 further cycles. With WAIT_LIMIT = 15 and sw stuck in MEMWR with `memReady` = 0 → TRAP after 16 cycles in MEMWR, memFault = 1.
- Mid-operation reset: `rst` asserted in MEMRD → state = 0 immediately (before the next edge); no RegWrite pulse seen; flags cleared.
